// File: rtl/mult_share_arbiter_if.sv
// Handshake/bus bundle between requesters, the shared multiplier and the arbiter.
// The arbiter uses the slave view; requesters, the multiplier and the response consumer use the master view.
interface mult_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              mult_start;
    logic [W-1:0]      mult_a;
    logic [W-1:0]      mult_b;
    logic              mult_valid;
    logic [2*W-1:0]    mult_c;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_data;
    logic              rsp_err;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, mult_valid, mult_c, rsp_ready,
        output req_ready, mult_start, mult_a, mult_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req_valid, req_a, req_b, mult_valid, mult_c, rsp_ready,
        input  req_ready, mult_start, mult_a, mult_b, rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one serial signed multiplier among NREQ requesters, one operation in flight.
// Latency: accept cycle 0, mult_start cycle 1, response registered one cycle after mult_valid.
// Backpressure: response held stable until rsp_ready; no accept while busy. WAIT abort via MULT_SHARE_ARB_TIMEOUT_EN.
module mult_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                rst,
    mult_share_arbiter_if.slave ifc
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] cand;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;

    if (IDW < $clog2(NREQ) || NREQ < 2 || TIMEOUT < 1) begin : g_param_check
        $error("mult_share_arbiter: inconsistent NREQ/IDW/TIMEOUT");
    end

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
`else
    assign ifc.rsp_err = 1'b0;
`endif

    // First asserted request at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr) + i) % NREQ);
            if (!grant_found && ifc.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        ifc.req_ready = '0;
        if (state == IDLE && grant_found) ifc.req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            id_q           <= '0;
            ifc.mult_start <= 1'b0;
            ifc.mult_a     <= '0;
            ifc.mult_b     <= '0;
            ifc.rsp_valid  <= 1'b0;
            ifc.rsp_id     <= '0;
            ifc.rsp_data   <= '0;
            ifc.busy       <= 1'b0;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
            wait_cnt       <= '0;
            ifc.rsp_err    <= 1'b0;
`endif
        end else begin
            ifc.mult_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        ifc.mult_a     <= ifc.req_a[grant_idx*W +: W];
                        ifc.mult_b     <= ifc.req_b[grant_idx*W +: W];
                        id_q           <= grant_idx;
                        ifc.mult_start <= 1'b1;
                        ifc.busy       <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    // A result arriving on the timeout cycle still wins.
                    if (ifc.mult_valid) begin
                        ifc.rsp_data  <= ifc.mult_c;
                        ifc.rsp_id    <= id_q;
                        ifc.rsp_valid <= 1'b1;
                        state         <= RESP;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
                        ifc.rsp_err   <= 1'b0;
                    end else if (wait_cnt == CW'(TIMEOUT)) begin
                        ifc.rsp_data  <= '0;
                        ifc.rsp_id    <= id_q;
                        ifc.rsp_valid <= 1'b1;
                        ifc.rsp_err   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (ifc.rsp_ready) begin
                        ptr           <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                        ifc.rsp_valid <= 1'b0;
                        ifc.busy      <= 1'b0;
                        state         <= IDLE;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
                        ifc.rsp_err   <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed steps plus randomized transactions against a round-robin model,
// with a 9-cycle serial multiplier model driven from the falling edge.
module tb_mult_share_arbiter;
    localparam int NREQ = 4, W = 4, IDW = 2, TIMEOUT = 31, MUL_LAT = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   ptr_m = 0;
    logic mute = 1'b0;
    logic spur = 1'b0;
    int   mdl_cnt = 0;
    logic mdl_valid = 1'b0;
    logic [2*W-1:0] mdl_c = '0;
    logic signed [2*W-1:0] ma, mb;
    logic [IDW-1:0] last_id;
    logic [2*W-1:0] last_data;

    mult_share_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) ifc ();

    mult_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc)
    );

    always #5 clk = ~clk;

    // Multiplier model: valid MUL_LAT cycles after the start cycle, product sign-extended.
    always @(negedge clk) begin
        mdl_valid = 1'b0;
        if (mdl_cnt > 0) begin
            mdl_cnt = mdl_cnt - 1;
            if (mdl_cnt == 0 && !mute) begin
                mdl_valid = 1'b1;
                mdl_c     = ma * mb;
            end
        end
        if (ifc.mult_start === 1'b1) begin
            mdl_cnt = MUL_LAT;
            ma = $signed(ifc.mult_a);
            mb = $signed(ifc.mult_b);
        end
    end

    assign ifc.mult_valid = mdl_valid | spur;
    assign ifc.mult_c     = mdl_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        logic [NREQ-1:0] t;
        for (int k = 0; k < NREQ; k++) begin
            t = v >> ((p + k) % NREQ);
            if (t[0]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic chk_reset(input string t);
        chk({t, "_req_ready"}, ifc.req_ready, 0);
        chk({t, "_start"}, ifc.mult_start, 0);
        chk({t, "_mult_a"}, ifc.mult_a, 0);
        chk({t, "_mult_b"}, ifc.mult_b, 0);
        chk({t, "_rsp_valid"}, ifc.rsp_valid, 0);
        chk({t, "_rsp_id"}, ifc.rsp_id, 0);
        chk({t, "_rsp_data"}, ifc.rsp_data, 0);
        chk({t, "_rsp_err"}, ifc.rsp_err, 0);
        chk({t, "_busy"}, ifc.busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.req_valid = '0;
        ifc.rsp_ready = 1'b0;
        spur = 1'b0;
        step();
        step();
        rst = 1'b0;
        ptr_m = 0;
        chk_reset("rst");
    endtask

    task automatic run_txn(input logic [NREQ-1:0] vld, input logic [NREQ*W-1:0] av,
                           input logic [NREQ*W-1:0] bv, input int stall, input bit spur_issue);
        int win, c;
        logic [W-1:0] ea, eb;
        logic signed [2*W-1:0] sa, sb;
        logic [2*W-1:0] exp_p;
        logic [NREQ-1:0] onehot;
        win    = rr_pick(vld, ptr_m);
        ea     = av[win*W +: W];
        eb     = bv[win*W +: W];
        sa     = $signed(ea);
        sb     = $signed(eb);
        exp_p  = sa * sb;
        onehot = NREQ'(1) << win;
        ifc.req_valid = vld;
        ifc.req_a     = av;
        ifc.req_b     = bv;
        ifc.rsp_ready = (stall == 0);
        #1;
        chk("grant", ifc.req_ready, onehot);
        step();
        chk("issue_start", ifc.mult_start, 1);
        chk("issue_rdy", ifc.req_ready, 0);
        chk("issue_busy", ifc.busy, 1);
        chk("op_a", ifc.mult_a, ea);
        chk("op_b", ifc.mult_b, eb);
        spur = spur_issue;
        c = 1;
        while (ifc.rsp_valid !== 1'b1 && c < 100) begin
            step();
            spur = 1'b0;
            c++;
            if (c == 2) chk("start_pulse", ifc.mult_start, 0);
            if (c == 5) chk("wait_rdy", ifc.req_ready, 0);
        end
        chk("rsp_latency", c, 11);
        chk("rsp_id", ifc.rsp_id, win);
        chk("rsp_data", ifc.rsp_data, exp_p);
        chk("rsp_err", ifc.rsp_err, 0);
        chk("op_a_hold", ifc.mult_a, ea);
        last_id   = ifc.rsp_id;
        last_data = ifc.rsp_data;
        for (int s = 0; s < stall; s++) begin
            step();
            chk("bp_valid", ifc.rsp_valid, 1);
            chk("bp_data", ifc.rsp_data, exp_p);
            chk("bp_id", ifc.rsp_id, win);
            chk("bp_rdy", ifc.req_ready, 0);
            chk("bp_start", ifc.mult_start, 0);
        end
        ifc.rsp_ready = 1'b1;
        step();
        ifc.rsp_ready = 1'b0;
        chk("rsp_clear", ifc.rsp_valid, 0);
        chk("back_idle", ifc.busy, 0);
        ptr_m = (win + 1) % NREQ;
    endtask

    initial begin
        int c;
        logic [NREQ-1:0] v;
        ifc.req_valid = '0;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.rsp_ready = 1'b0;
        do_reset();

        // Spurious mult_valid while idle
        spur = 1'b1;
        step();
        spur = 1'b0;
        chk("idle_spur_busy", ifc.busy, 0);
        chk("idle_spur_rsp", ifc.rsp_valid, 0);
        chk("idle_spur_start", ifc.mult_start, 0);

        // Single request from requester 1: -3 * 5
        run_txn(4'b0010, 16'h00D0, 16'h0050, 0, 1'b0);
        chk("single_id", last_id, 1);
        chk("single_data", last_data, 8'hF1);

        // Requesters 0 and 2 held back-to-back
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_txn(4'b0101, 16'($urandom), 16'($urandom), 0, 1'b0);
            chk("rr02_order", last_id, (k % 2) * 2);
        end

        // All requesters from reset
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_txn(4'b1111, 16'($urandom), 16'($urandom), 0, 1'b0);
            chk("rr_all_order", last_id, k % 4);
        end

        // Response backpressure for 5 cycles
        run_txn(4'b0100, 16'($urandom), 16'($urandom), 5, 1'b0);

        // Spurious mult_valid in ISSUE, boundary product -8 * -8
        run_txn(4'b1000, 16'h8000, 16'h8000, 0, 1'b1);
        chk("boundary_data", last_data, 8'h40);

        // Synchronous reset during WAIT; later multiplier result must be ignored
        ifc.req_valid = 4'b0001;
        step();
        step();
        step();
        chk("pre_rst_busy", ifc.busy, 1);
        rst = 1'b1;
        ifc.req_valid = '0;
        step();
        rst = 1'b0;
        ptr_m = 0;
        chk_reset("wait_rst");
        for (int k = 0; k < 12; k++) begin
            step();
            chk("post_rst_rsp", ifc.rsp_valid, 0);
            chk("post_rst_busy", ifc.busy, 0);
        end

        // Multiplier that never answers
        mute = 1'b1;
        ifc.rsp_ready = 1'b0;
        ifc.req_valid = 4'b0001;
        step();
        ifc.req_valid = '0;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
        c = 1;
        while (ifc.rsp_valid !== 1'b1 && c < 200) begin
            step();
            c++;
        end
        chk("to_latency", c, TIMEOUT + 3);
        chk("to_err", ifc.rsp_err, 1);
        chk("to_data", ifc.rsp_data, 0);
        chk("to_id", ifc.rsp_id, 0);
        ifc.rsp_ready = 1'b1;
        step();
        ifc.rsp_ready = 1'b0;
        chk("to_err_clear", ifc.rsp_err, 0);
        chk("to_rsp_clear", ifc.rsp_valid, 0);
        ptr_m = 1;
        mute = 1'b0;
`else
        c = 0;
        for (int k = 0; k < 150; k++) begin
            step();
            if (ifc.rsp_valid !== 1'b0) c++;
        end
        chk("hang_busy", ifc.busy, 1);
        chk("hang_no_rsp", c, 0);
        chk("hang_err", ifc.rsp_err, 0);
        mute = 1'b0;
        do_reset();
`endif

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_txn(v, 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one serial signed multiplier (start/valid handshake, fixed multi-cycle latency) between NREQ requesters.
- Round-robin arbitration; latches the winner's operands, pulses the multiplier's start, waits for its valid, then returns the product tagged with the requester index.
- Sits between requester blocks and the single multiplier instance; only one operation is ever in flight.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, operand width; product is 2*W, matching the multiplier.
- IDW, 2, requester index width; must be at least clog2(NREQ).
- TIMEOUT, 31, maximum cycles spent in WAIT before abort (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot accept pulse.
- req_a  in  NREQ*W  packed signed operand A; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  packed signed operand B, same packing.
- mult_start  out  1  start pulse to the multiplier.
- mult_a  out  W  operand A to the multiplier.
- mult_b  out  W  operand B to the multiplier.
- mult_valid  in  1  multiplier result-valid.
- mult_c  in  2*W  multiplier product.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that issued the operation.
- rsp_data  out  2*W  signed product.
- rsp_err  out  1  timeout flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. A clocked rst forces IDLE and clears every register.
- Reset values: req_ready=0, mult_start=0, mult_a=mult_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0, priority pointer=0 (requester 0 highest).
- Reset mid-operation aborts without a response. Any in-flight multiplier result is ignored. The multiplier has its own reset, owned by the integrator.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is high, choose the winner: the first asserted index at or after the pointer, wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally in that cycle only; the accept is this cycle's handshake.
  - On that edge: latch operands into mult_a/mult_b and the index into an id register; go to ISSUE.
  - req_ready is never high outside IDLE.
- ISSUE: mult_start=1 for exactly this one cycle; go to WAIT.
- mult_a/mult_b hold stable from ISSUE through RESP.
- WAIT: on mult_valid=1, register mult_c into rsp_data and the id into rsp_id; go to RESP.
- mult_valid is ignored in every state except WAIT.
- RESP:
  - rsp_valid=1 and rsp_data/rsp_id stay stable until rsp_ready=1.
  - On that edge: pointer becomes winner+1 (wrapping modulo NREQ), rsp_valid clears, state goes to IDLE.
  - rsp_ready is ignored outside RESP.
- Latency: accept at cycle 0, mult_start at cycle 1, rsp_valid one cycle after mult_valid. With a multiplier whose valid arrives 9 cycles after start, rsp_valid first asserts at cycle 11.
- Throughput: with rsp_ready held high, the next accept is possible on the cycle after the RESP handshake.
- Arithmetic: none in this block; operands and product pass through bit-exact. Signedness is the multiplier's concern.
- A requester that drops req_valid before it is granted is simply not selected; no request is queued.
- busy = (state != IDLE).

Optional Feature:
- Macro MULT_SHARE_ARB_TIMEOUT_EN.
- Defined: a cycle counter clears on entry to WAIT and increments every WAIT cycle.
  - If it reaches TIMEOUT with no mult_valid, go to RESP with rsp_data=0 and rsp_err=1.
  - rsp_err clears on the RESP handshake.
  - A mult_valid arriving in the same cycle as the timeout wins: normal response, rsp_err=0.
- Not defined: no counter; WAIT persists indefinitely; rsp_err is tied to 0.

Test Plan:
- Reset then single request: req_valid[1]=1, a=4'hD (-3), b=4'h5, rsp_ready=1 -> req_ready=4'b0010 at cycle 0, one-cycle mult_start at cycle 1, rsp_valid at cycle 11 with rsp_id=1, rsp_data=8'hF1 (-15), rsp_err=0.
- Round-robin: requesters 0 and 2 held valid back-to-back -> grant order 0,2,0,2. Then requesters 0..3 all valid from reset -> order 0,1,2,3,0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; no req_ready; mult_start stays 0.
- Spurious mult_valid pulsed in IDLE and ISSUE -> no state change and no response. Boundary product a=4'h8, b=4'h8 -> rsp_data=8'h40.
- Synchronous reset asserted during WAIT -> next cycle IDLE, all outputs at reset values; the multiplier's later mult_valid is ignored.
- With MULT_SHARE_ARB_TIMEOUT_EN and a multiplier model that never asserts valid -> rsp_valid with rsp_err=1 and rsp_data=0, TIMEOUT+1 cycles after entering WAIT. Without the macro -> busy stays high indefinitely.
